// File: rtl/axi4full_sub_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi4_sub_pkg                                               |
// | Desc    : Shared types and constants for the AXI4-full subordinate.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package axi4_sub_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wstate_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4full_sub_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi4full_sub_mem_if                                        |
// | Desc    : AXI4-full bus bundle with manager/subordinate modports.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface axi4full_sub_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [7:0]              S_AXI_AWLEN;
   logic [1:0]              S_AXI_AWBURST;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WLAST;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [7:0]              S_AXI_ARLEN;
   logic [1:0]              S_AXI_ARBURST;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]              S_AXI_RRESP;
   logic                    S_AXI_RLAST;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axi4full_sub_mem_burst_addr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi4_sub_burst_addr                                        |
// | Desc    : Next word index for a burst beat plus illegal-burst flag.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module axi4_sub_burst_addr
   import axi4_sub_pkg::*;
#(
   parameter int IDX_WIDTH = 4
) (
   input  wire logic                 i_load,
   input  wire logic                 i_step,
   input  wire burst_t               i_burst,
   input  wire logic [IDX_WIDTH-1:0] i_load_index,
   input  wire logic [IDX_WIDTH-1:0] i_cur_index,
   output logic      [IDX_WIDTH-1:0] o_next_index,
   output logic                      o_illegal
);
   always_comb begin
      o_next_index = i_cur_index;
      if (i_load) begin
         o_next_index = i_load_index;
      end else if (i_step && (i_burst == BURST_INCR)) begin
         // natural overflow wraps to word 0 at the top of memory
         o_next_index = i_cur_index + IDX_WIDTH'(1);
      end
   end

   assign o_illegal = i_burst[1];
endmodule
`default_nettype wire

// File: rtl/axi4full_sub_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axi4full_sub_mem                                           |
// | Desc    : AXI4-full subordinate over a flop-based register memory.   |
// |           Optional AXI4_SUB_PROT_CHECK_EN guards the upper half.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module axi4full_sub_mem
   import axi4_sub_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  wire logic         S_AXI_ACLK,
   input  wire logic         S_AXI_ARESETN,
   axi4full_sub_mem_if.slave s_axi
);
   localparam int ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
   localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int DEPTH    = 1 << IDX_W;
   localparam int NBYTES   = C_S_AXI_DATA_WIDTH / 8;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

   wstate_t    r_wstate, w_wstate_nxt;
   logic       r_awready, r_wready, r_bvalid;
   logic [1:0] r_bresp;
   logic [IDX_W-1:0] r_widx, w_widx_nxt;
   logic [7:0] r_wlen, r_wbeat;
   burst_t     r_wburst, w_wburst_sel;
   logic       r_werr, r_wover, r_wlenerr;
   logic       w_aw_hs, w_w_hs, w_wstep, w_wlast_exp, w_wbad, w_wprot;

   rstate_t    r_rstate, w_rstate_nxt;
   logic       r_arready, r_rvalid, r_rlast;
   logic [1:0] r_rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [IDX_W-1:0] r_ridx, w_ridx_nxt;
   logic [7:0] r_rlen, r_rbeat;
   burst_t     r_rburst, w_rburst_sel;
   logic       r_rerr, w_rerr_sel;
   logic       w_ar_hs, w_r_hs, w_rstep, w_rbad, w_rprot;

`ifdef AXI4_SUB_PROT_CHECK_EN
   assign w_wprot = !s_axi.S_AXI_AWPROT[0] && s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1];
   assign w_rprot = !s_axi.S_AXI_ARPROT[0] && s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1];
   wire w_unused_prot = ^{s_axi.S_AXI_AWPROT[2:1], s_axi.S_AXI_ARPROT[2:1]};
`else
   assign w_wprot = 1'b0;
   assign w_rprot = 1'b0;
   wire w_unused_prot = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
`endif
   wire w_unused_addr = ^{s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

   // ---------------- write path ----------------
   assign w_aw_hs      = s_axi.S_AXI_AWVALID && r_awready;
   assign w_w_hs       = s_axi.S_AXI_WVALID && r_wready;
   assign w_wstep      = w_w_hs && !r_wover;
   assign w_wlast_exp  = !r_wover && (r_wbeat == r_wlen);
   assign w_wburst_sel = w_aw_hs ? burst_t'(s_axi.S_AXI_AWBURST) : r_wburst;

   axi4_sub_burst_addr #(.IDX_WIDTH(IDX_W)) u_waddr (
      .i_load       (w_aw_hs),
      .i_step       (w_wstep),
      .i_burst      (w_wburst_sel),
      .i_load_index (s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
      .i_cur_index  (r_widx),
      .o_next_index (w_widx_nxt),
      .o_illegal    (w_wbad)
   );

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
         W_DATA:  if (w_w_hs && s_axi.S_AXI_WLAST) w_wstate_nxt = W_RESP;
         W_RESP:  if (r_bvalid && s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_widx    <= '0;
         r_wlen    <= '0;
         r_wbeat   <= '0;
         r_wburst  <= BURST_FIXED;
         r_werr    <= 1'b0;
         r_wover   <= 1'b0;
         r_wlenerr <= 1'b0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_awready <= (w_wstate_nxt == W_IDLE);
         r_wready  <= (w_wstate_nxt == W_DATA);
         r_bvalid  <= (w_wstate_nxt == W_RESP);
         r_widx    <= w_widx_nxt;
         if (w_aw_hs) begin
            r_wlen    <= s_axi.S_AXI_AWLEN;
            r_wburst  <= burst_t'(s_axi.S_AXI_AWBURST);
            r_wbeat   <= '0;
            r_werr    <= w_wbad || w_wprot;
            r_wover   <= 1'b0;
            r_wlenerr <= 1'b0;
         end else if (w_w_hs) begin
            if (!r_wover) r_wbeat <= r_wbeat + 8'd1;
            // beat AWLEN without WLAST: flag it and swallow the surplus beats
            if (w_wlast_exp && !s_axi.S_AXI_WLAST) begin
               r_wover   <= 1'b1;
               r_wlenerr <= 1'b1;
            end
         end
         if (w_w_hs && s_axi.S_AXI_WLAST)
            r_bresp <= (r_werr || r_wlenerr || !w_wlast_exp) ? RESP_SLVERR : RESP_OKAY;
         else if (r_bvalid && s_axi.S_AXI_BREADY)
            r_bresp <= RESP_OKAY;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wstep && !r_werr) begin
         for (int b = 0; b < NBYTES; b++)
            if (s_axi.S_AXI_WSTRB[b]) r_mem[r_widx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
      end
   end

   // ---------------- read path ----------------
   assign w_ar_hs      = s_axi.S_AXI_ARVALID && r_arready;
   assign w_r_hs       = r_rvalid && s_axi.S_AXI_RREADY;
   assign w_rstep      = w_r_hs && !r_rlast;
   assign w_rburst_sel = w_ar_hs ? burst_t'(s_axi.S_AXI_ARBURST) : r_rburst;
   assign w_rerr_sel   = w_ar_hs ? (w_rbad || w_rprot) : r_rerr;

   axi4_sub_burst_addr #(.IDX_WIDTH(IDX_W)) u_raddr (
      .i_load       (w_ar_hs),
      .i_step       (w_rstep),
      .i_burst      (w_rburst_sel),
      .i_load_index (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
      .i_cur_index  (r_ridx),
      .o_next_index (w_ridx_nxt),
      .o_illegal    (w_rbad)
   );

   always_comb begin
      w_rstate_nxt = r_rstate;
      if (r_rstate == R_IDLE) begin
         if (w_ar_hs) w_rstate_nxt = R_DATA;
      end else begin
         if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
         r_ridx    <= '0;
         r_rlen    <= '0;
         r_rbeat   <= '0;
         r_rburst  <= BURST_FIXED;
         r_rerr    <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= (w_rstate_nxt == R_IDLE);
         r_rvalid  <= (w_rstate_nxt == R_DATA);
         r_ridx    <= w_ridx_nxt;
         if (w_ar_hs) begin
            r_rlen   <= s_axi.S_AXI_ARLEN;
            r_rburst <= burst_t'(s_axi.S_AXI_ARBURST);
            r_rbeat  <= '0;
            r_rerr   <= w_rerr_sel;
         end else if (w_rstep) begin
            r_rbeat  <= r_rbeat + 8'd1;
         end
         // memory is sampled before any same-cycle write lands, so reads see old data
         if (w_ar_hs || w_rstep) begin
            r_rdata <= w_rerr_sel ? '0 : r_mem[w_ridx_nxt];
            r_rresp <= w_rerr_sel ? RESP_SLVERR : RESP_OKAY;
            r_rlast <= w_ar_hs ? (s_axi.S_AXI_ARLEN == 8'd0) : ((r_rbeat + 8'd1) == r_rlen);
         end else if (w_r_hs) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_rlast <= 1'b0;
         end
      end
   end

   assign s_axi.S_AXI_AWREADY = r_awready;
   assign s_axi.S_AXI_WREADY  = r_wready;
   assign s_axi.S_AXI_BVALID  = r_bvalid;
   assign s_axi.S_AXI_BRESP   = r_bresp;
   assign s_axi.S_AXI_ARREADY = r_arready;
   assign s_axi.S_AXI_RVALID  = r_rvalid;
   assign s_axi.S_AXI_RDATA   = r_rdata;
   assign s_axi.S_AXI_RRESP   = r_rresp;
   assign s_axi.S_AXI_RLAST   = r_rlast;
endmodule
`default_nettype wire
